// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared FSM encoding, register map and CUR layout for irq_ctrl.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  // Register indices selected by Addr[3:2]
  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_MODE = 2'd2;
  localparam logic [1:0] REG_CUR  = 2'd3;

  localparam int CUR_VALID_BIT = 31;
  localparam int CUR_ID_W      = 3;

  typedef struct packed {
    logic                valid;
    logic [CUR_ID_W-1:0] id;
  } cur_t;

endpackage

// File: rtl/irq_src_cell.sv
// irq_src_cell: one interrupt source -- input sample, edge detect and the
// PEND bit with set-over-clear priority.
// Build option IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer on the raw line.
module irq_src_cell
  import irq_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic irq,      // raw line
  input  logic mode,     // 1 = edge, 0 = level
  input  logic w1c,      // software clear
  input  logic ack_hit,  // CP0 took this source
  output logic pend,
  output logic pend_d    // next-cycle PEND, lets the FSM see same-cycle drops
);

  logic irq_s, irq_q, set, clr;

`ifdef IRQ_CTRL_SYNC_EN
  logic [1:0] sync;
  // Two-stage synchronizer for asynchronous peripheral lines
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync <= '0;
    else        sync <= {sync[0], irq};
  assign irq_s = sync[1];
`else
  assign irq_s = irq;
`endif

  // Ack only consumes edge-latched requests; level sources follow the line
  assign set    = mode ? (irq_s & ~irq_q) : irq_s;
  assign clr    = w1c | (ack_hit & mode);
  assign pend_d = set | (pend & ~clr);

  // Prior-cycle sample and pending bit
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      irq_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      irq_q <= irq_s;
      pend  <= pend_d;
    end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller (MASK/PEND/MODE/CUR) with a
// single-request IDLE/REQ/SERVICE handshake towards CP0.
// Build option IRQ_CTRL_SYNC_EN synchronizes irq_in (edge->IntReq 4 cycles).
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:2]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             ack,
  input  logic             eret,
  output logic [N_SRC-1:0] HWInt,
  output logic             IntReq
);

  irq_state_e state, state_nxt;
  cur_t       cur, cur_nxt;

  logic [N_SRC-1:0]    mask, mode, mask_d;
  logic [N_SRC-1:0]    pend, pend_d, w1c, req_vec, id_hot, ack_hit;
  logic [1:0]          sel;
  logic                wr_mask, wr_pend, wr_mode, wr_cur, ack_take, cur_live;
  logic [CUR_ID_W-1:0] pri_id;

  // Upper address/data bits have no register behind them
  logic unused_bits;
  assign unused_bits = ^{Addr[31:4], Din[31:N_SRC]};

  assign sel     = Addr[3:2];
  assign wr_mask = WE && (sel == REG_MASK);
  assign wr_pend = WE && (sel == REG_PEND);
  assign wr_mode = WE && (sel == REG_MODE);
  assign wr_cur  = WE && (sel == REG_CUR);

  assign mask_d   = wr_mask ? Din[N_SRC-1:0] : mask;
  assign w1c      = wr_pend ? Din[N_SRC-1:0] : '0;
  assign ack_take = (state == ST_REQ) && ack;
  assign req_vec  = pend & mask;
  // Current request is still live after this cycle's writes/clears
  assign cur_live = |(mask_d & pend_d & id_hot);

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign id_hot[i]  = (cur.id == CUR_ID_W'(i));
    assign ack_hit[i] = ack_take & id_hot[i];

    irq_src_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .irq     (irq_in[i]),
      .mode    (mode[i]),
      .w1c     (w1c[i]),
      .ack_hit (ack_hit[i]),
      .pend    (pend[i]),
      .pend_d  (pend_d[i])
    );
  end

  // Lowest set index wins
  always_comb begin
    pri_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (req_vec[i]) pri_id = CUR_ID_W'(i);
  end

  // MASK/MODE registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mask <= '0;
      mode <= '0;
    end else begin
      mask <= mask_d;
      if (wr_mode) mode <= Din[N_SRC-1:0];
    end

  // FSM and CUR state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ST_IDLE;
      cur   <= '0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
    end

  // Next-state: one request in flight, no nesting
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    case (state)
      ST_IDLE:
        if (|req_vec) begin
          state_nxt     = ST_REQ;
          cur_nxt.valid = 1'b1;
          cur_nxt.id    = pri_id;
        end
      ST_REQ:
        if (ack) begin
          state_nxt = ST_SERVICE;
        end else if (!cur_live) begin
          state_nxt = ST_IDLE;
          cur_nxt   = '0;
        end
      ST_SERVICE:
        if (eret || wr_cur) begin
          state_nxt = ST_IDLE;
          cur_nxt   = '0;
        end
      default: begin
        state_nxt = ST_IDLE;
        cur_nxt   = '0;
      end
    endcase
  end

  // Register read mux
  always_comb begin
    Dout = '0;
    case (sel)
      REG_MASK: Dout[N_SRC-1:0] = mask;
      REG_PEND: Dout[N_SRC-1:0] = pend;
      REG_MODE: Dout[N_SRC-1:0] = mode;
      REG_CUR: begin
        Dout[CUR_VALID_BIT]  = cur.valid;
        Dout[CUR_ID_W-1:0]   = cur.id;
      end
      default: Dout = '0;
    endcase
  end

  assign HWInt  = req_vec;
  assign IntReq = (state == ST_REQ);

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter N_SRC, default 6, number of interrupt sources (bit i = source i; index 0 highest priority).
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Addr  input  30 ([31:2])  word address; Addr[3:2] selects register.
REQ-005 WE  input  1  register write strobe, sampled on posedge clk.
REQ-006 Din  input  32  write data.
REQ-007 Dout  output  32  combinational read of the register selected by Addr[3:2].
REQ-008 irq_in  input  N_SRC  raw interrupt lines from timers and peripherals.
REQ-009 ack  input  1  one-cycle pulse from CP0 when the exception is taken.
REQ-010 eret  input  1  one-cycle pulse from CP0 on ERET, ending service.
REQ-011 HWInt  output  N_SRC  PEND & MASK, feeding CP0 Cause.IP.
REQ-012 IntReq  output  1  high exactly while the FSM is in REQ.

Function
REQ-013 Registers SHALL be: 0 MASK (rw, low N_SRC bits); 1 PEND (read; write-1-to-clear); 2 MODE (rw; bit=1 edge, 0 level); 3 CUR (read {valid[31], id[2:0]}; any write acts as eret).
REQ-014 Unimplemented bits SHALL read 0; writes to them SHALL be ignored.
REQ-015 Edge source SHALL set PEND[i] on irq_in[i] & ~irq_q[i] (irq_q = prior-cycle sample); level source SHALL set PEND[i] while irq_in[i]=1.
REQ-016 A PEND set condition SHALL win over a same-cycle W1C clear or ack clear of that bit.
REQ-017 Level source SHALL clear PEND[i] only by W1C after the line drops; re-sets next cycle if still high.
REQ-018 FSM states SHALL be IDLE, REQ, SERVICE.
REQ-019 IDLE: if |(PEND & MASK), latch lowest set index into CUR.id, set CUR.valid, go REQ next cycle.
REQ-020 REQ: on ack go SERVICE and clear PEND[CUR.id] if that source is edge mode; if MASK[CUR.id] or PEND[CUR.id] drops before ack, clear CUR.valid and return to IDLE.
REQ-021 SERVICE: on eret or CUR write go IDLE and clear CUR.valid; new requests stay pending, no nesting.
REQ-022 ack outside REQ and eret outside SERVICE SHALL be ignored.
REQ-023 Latency: irq_in edge at cycle t -> PEND at t+1 -> IntReq at t+2 (from IDLE).
REQ-024 Register writes SHALL be processed in the same cycle as FSM updates; no write stalls the FSM.

Reset
REQ-025 reset low SHALL asynchronously clear MASK, PEND, MODE, CUR, irq_q and FSM to IDLE; HWInt=0, IntReq=0, Dout reflects zeroed registers.
REQ-026 Reset mid-REQ or mid-SERVICE SHALL abandon the request; no pending state survives.

Configuration
REQ-027 Macro IRQ_CTRL_SYNC_EN: when defined, irq_in SHALL pass a 2-flop synchronizer before edge/level logic (latency edge->IntReq = 4 cycles); when undefined, irq_in used directly (2 cycles).

Structure
REQ-028 Shared package irq_ctrl_pkg SHALL hold FSM state encoding, register index constants (MASK/PEND/MODE/CUR) and CUR.valid bit position.
REQ-029 Per-source pending logic (sample, edge detect, set/clear priority) SHALL be one sub-module irq_src_cell, instantiated N_SRC times.
REQ-030 Priority encoder and FSM SHALL remain in irq_ctrl.

Verification
REQ-031 MASK=0x04, MODE=0x04, pulse irq_in[2] one cycle -> PEND=0x04 next cycle, IntReq next, CUR=0x8000_0002; ack -> PEND=0, SERVICE; eret -> IDLE, CUR=0.
REQ-032 MASK=0x3F, irq_in[1] and irq_in[4] rise same cycle (edge) -> CUR.id=1 first; after ack/eret, IDLE re-enters REQ with CUR.id=4.
REQ-033 Level source 3 held high, W1C 0x08 to PEND same cycle -> PEND[3] remains 1.
REQ-034 In REQ for id 0, write MASK=0 before ack -> IntReq low next cycle, CUR.valid=0, PEND[0] still 1, HWInt=0.
REQ-035 Assert reset low during SERVICE -> all registers 0, IntReq=0 immediately, FSM IDLE after release.
REQ-036 With IRQ_CTRL_SYNC_EN defined, edge on irq_in[0] at t -> IntReq first high at t+4; undefined -> t+2.
